wash_sequencer: RTL and testbench

Parametrised successor of the key-count / arm-delay / countdown controller in the wash system. Counts debounced key pulses into a program selection, arms after a configurable idle period, runs a countdown proportional to the selection and flags completion or selection overflow. Sits between the key debouncers and the display mux/driver, and replaces the separate counter, delay and overflow-flag blocks with one clocked FSM that has its own tick prescaler.

---
 rtl/wash_pkg.sv | 29 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/wash_sequencer.sv | 169 ++++++++++++++++
 tb/tb_wash_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared state encoding and width helpers for wash_sequencer.
// Defining WASH_PAUSE_EN adds the PAUSE state to the encoding.
package wash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_RUN    = 3'd2,
`ifdef WASH_PAUSE_EN
    ST_PAUSE  = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ALARM  = 3'd5
  } state_e;

  function automatic int sel_w(input int max_sel);
    return $clog2(max_sel + 1);
  endfunction

  function automatic int rem_w(input int max_sel, input int run_scale);
    return $clog2(max_sel * run_scale + 1);
  endfunction

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-TICK_DIV counter; tick is high in the last cycle of each period.
// clear restarts the period so the next tick is TICK_DIV cycles away.
module tick_prescaler
  import wash_pkg::*;
#(
  parameter int TICK_DIV = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wash_sequencer.sv
// Key-count / arm-delay / countdown controller for the wash system.
// Build with WASH_PAUSE_EN defined to let a key pause and resume the countdown.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int MAX_SEL   = 15,
  parameter int TICK_DIV  = 10000,
  parameter int ARM_TICKS = 5,
  parameter int RUN_SCALE = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  key_pulse,
  input  logic                                  cancel,
  output logic [rem_w(MAX_SEL, RUN_SCALE)-1:0]  disp_value,
  output logic                                  running,
  output logic                                  done,
  output logic                                  alarm
);

  localparam int SEL_W = sel_w(MAX_SEL);
  localparam int REM_W = rem_w(MAX_SEL, RUN_SCALE);
  localparam int ARM_W = sel_w(ARM_TICKS);
  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(MAX_SEL);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TICKS);
  localparam logic [REM_W-1:0] SCALE    = REM_W'(RUN_SCALE);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] disp_q, disp_d;
  logic             running_q, running_d, done_q, done_d, alarm_q, alarm_d;
  logic             tick, key_accepted, pre_clear;

  // Every state entry and every honoured key restarts the tick period.
  assign pre_clear = key_accepted || (state_d != state_q);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    arm_cnt_d    = arm_cnt_q;
    rem_d        = rem_q;
    key_accepted = 1'b0;
    if (cancel) begin
      state_d   = ST_IDLE;
      sel_d     = '0;
      rem_d     = '0;
      arm_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (key_pulse) begin
          key_accepted = 1'b1;
          state_d      = ST_SELECT;
          sel_d        = SEL_W'(1);
          arm_cnt_d    = '0;
        end
        ST_SELECT: begin
          if (key_pulse) begin
            key_accepted = 1'b1;
            if (sel_q < SEL_MAX) begin
              sel_d     = sel_q + 1'b1;
              arm_cnt_d = '0;
            end else begin
              state_d = ST_ALARM;
            end
          end else if (tick) begin
            arm_cnt_d = arm_cnt_q + 1'b1;
            if (arm_cnt_d == ARM_LAST) begin
              state_d = ST_RUN;
              rem_d   = REM_W'(sel_q) * SCALE;
            end
          end
        end
        ST_RUN: begin
`ifdef WASH_PAUSE_EN
          if (key_pulse) begin
            key_accepted = 1'b1;
            state_d      = ST_PAUSE;
          end else
`endif
          if (tick) begin
            if (rem_q == REM_W'(1)) begin
              state_d = ST_DONE;
              rem_d   = '0;
            end else begin
              rem_d = rem_q - 1'b1;
            end
          end
        end
`ifdef WASH_PAUSE_EN
        ST_PAUSE: if (key_pulse) begin
          key_accepted = 1'b1;
          state_d      = ST_RUN;
        end
`endif
        ST_DONE: if (key_pulse) begin
          key_accepted = 1'b1;
          state_d      = ST_IDLE;
          sel_d        = '0;
        end
        ST_ALARM: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    disp_d    = '0;
    running_d = 1'b0;
    done_d    = 1'b0;
    alarm_d   = 1'b0;
    case (state_d)
      ST_SELECT: disp_d = REM_W'(sel_d);
      ST_ALARM: begin
        disp_d  = REM_W'(sel_d);
        alarm_d = 1'b1;
      end
      ST_RUN: begin
        disp_d    = rem_d;
        running_d = 1'b1;
      end
`ifdef WASH_PAUSE_EN
      ST_PAUSE: begin
        disp_d    = rem_d;
        running_d = 1'b1;
      end
`endif
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      arm_cnt_q <= '0;
      rem_q     <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      arm_cnt_q <= arm_cnt_d;
      rem_q     <= rem_d;
      disp_q    <= disp_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  assign disp_value = disp_q;
  assign running    = running_q;
  assign done       = done_q;
  assign alarm      = alarm_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer against an elapsed-cycle reference model.
// Honours WASH_PAUSE_EN the same way as the design.
module tb_wash_sequencer;

  localparam int MAX_SEL = 5;
  localparam int TD      = 4;
  localparam int ARM     = 2;
  localparam int SCALE   = 3;

  localparam int M_IDLE = 0, M_SEL = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4, M_ALARM = 5;
`ifdef WASH_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0, cancel = 1'b0, key1 = 1'b0, cancel1 = 1'b0;
  logic [3:0] disp, disp1;
  logic       running, done, alarm, running1, done1, alarm1;
  logic [6:0] obs, obs1;

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus elapsed-cycle bookkeeping.
  int m_mode, m_sel, m_quiet, m_rem_base, m_seg;

  assign obs  = {disp, running, done, alarm};
  assign obs1 = {disp1, running1, done1, alarm1};

  always #5 clk = ~clk;

  wash_sequencer #(.MAX_SEL(MAX_SEL), .TICK_DIV(TD), .ARM_TICKS(ARM), .RUN_SCALE(SCALE)) dut (
    .clk(clk), .reset(reset), .key_pulse(key), .cancel(cancel),
    .disp_value(disp), .running(running), .done(done), .alarm(alarm)
  );

  wash_sequencer #(.MAX_SEL(MAX_SEL), .TICK_DIV(1), .ARM_TICKS(ARM), .RUN_SCALE(SCALE)) dut1 (
    .clk(clk), .reset(reset), .key_pulse(key1), .cancel(cancel1),
    .disp_value(disp1), .running(running1), .done(done1), .alarm(alarm1)
  );

  task automatic model_reset();
    m_mode = M_IDLE; m_sel = 0; m_quiet = 0; m_rem_base = 0; m_seg = 0;
  endtask

  function automatic int model_rem();
    return m_rem_base - m_seg / TD;
  endfunction

  task automatic model_step(input bit k, input bit c);
    if (c) begin
      m_mode = M_IDLE; m_sel = 0; m_rem_base = 0; m_seg = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (k) begin m_mode = M_SEL; m_sel = 1; m_quiet = 0; end
        M_SEL: begin
          if (k) begin
            if (m_sel < MAX_SEL) begin m_sel++; m_quiet = 0; end
            else m_mode = M_ALARM;
          end else begin
            m_quiet++;
            if (m_quiet == ARM * TD) begin m_mode = M_RUN; m_rem_base = m_sel * SCALE; m_seg = 0; end
          end
        end
        M_RUN: begin
          if (k && PAUSE_EN) begin
            m_rem_base = model_rem(); m_seg = 0; m_mode = M_PAUSE;
          end else begin
            m_seg++;
            if (model_rem() == 0) begin m_mode = M_DONE; m_rem_base = 0; m_seg = 0; end
          end
        end
        M_PAUSE: if (k) begin m_mode = M_RUN; m_seg = 0; end
        M_DONE: if (k) m_mode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [3:0] d;
    logic r, dn, a;
    d = '0; r = 1'b0; dn = 1'b0; a = 1'b0;
    case (m_mode)
      M_SEL: d = 4'(m_sel);
      M_ALARM: begin d = 4'(m_sel); a = 1'b1; end
      M_RUN, M_PAUSE: begin d = 4'(model_rem()); r = 1'b1; end
      M_DONE: dn = 1'b1;
      default: ;
    endcase
    return {d, r, dn, a};
  endfunction

  task automatic step(input bit k, input bit c);
    key = k; cancel = c;
    @(posedge clk);
    #1;
    key = 1'b0; cancel = 1'b0;
    model_step(k, c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL reset_main got=%h want=%h", obs, 7'd0); end
    checks++;
    if (obs1 !== 7'd0) begin errors++; $display("FAIL reset_div1 got=%h want=%h", obs1, 7'd0); end
    $display("scenario reset: outputs %h / %h", obs, obs1);
  endtask

  task automatic test_select_run();
    logic [6:0] want;
    for (int i = 0; i < 38; i++) begin
      step(bit'(i == 0 || i == 2 || i == 36), 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL select_run cyc=%0d got=%h want=%h", i, obs, model_out());
      end
      if (i == 0 || i == 2 || i == 10 || i == 34 || i == 36) begin
        want = (i == 0)  ? {4'd1, 3'b000} :
               (i == 2)  ? {4'd2, 3'b000} :
               (i == 10) ? {4'd6, 3'b100} :
               (i == 34) ? {4'd0, 3'b010} : 7'd0;
        checks++;
        if (obs !== want) begin errors++; $display("FAIL select_run_fixed cyc=%0d got=%h want=%h", i, obs, want); end
      end
    end
    $display("scenario select_run: final outputs %h", obs);
  endtask

  task automatic test_alarm();
    logic [6:0] want;
    for (int i = 0; i < 18; i++) begin
      step(bit'(i % 2 == 0 && i <= 14), bit'(i == 16));
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL alarm cyc=%0d got=%h want=%h", i, obs, model_out());
      end
      if (i == 10 || i == 14 || i == 16) begin
        want = (i == 16) ? 7'd0 : {4'd5, 3'b001};
        checks++;
        if (obs !== want) begin errors++; $display("FAIL alarm_fixed cyc=%0d got=%h want=%h", i, obs, want); end
      end
    end
    $display("scenario alarm: final outputs %h", obs);
  endtask

  task automatic test_rearm();
    logic [6:0] want;
    for (int i = 0; i < 29; i++) begin
      step(bit'(i == 0 || i == 6 || i == 12 || i == 18), bit'(i == 27));
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL rearm cyc=%0d got=%h want=%h", i, obs, model_out());
      end
      if (i == 25 || i == 26) begin
        want = (i == 25) ? {4'd4, 3'b000} : {4'd12, 3'b100};
        checks++;
        if (obs !== want) begin errors++; $display("FAIL rearm_fixed cyc=%0d got=%h want=%h", i, obs, want); end
      end
    end
    $display("scenario rearm: final outputs %h", obs);
  endtask

  task automatic test_cancel_reset();
    for (int i = 0; i < 15; i++) begin
      step(bit'(i == 0 || i == 2 || i == 4), bit'(i == 2));
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL cancel cyc=%0d got=%h want=%h", i, obs, model_out());
      end
      if (i == 2) begin
        checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL cancel_key cyc=%0d got=%h want=%h", i, obs, 7'd0); end
      end
      if (i == 13) begin
        checks++;
        if (obs !== {4'd3, 3'b100}) begin errors++; $display("FAIL cancel_run cyc=%0d got=%h want=%h", i, obs, {4'd3, 3'b100}); end
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs !== 7'd0) begin errors++; $display("FAIL async_reset got=%h want=%h", obs, 7'd0); end
    #2 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL post_reset cyc=%0d got=%h want=%h", i, obs, model_out());
      end
    end
    $display("scenario cancel_reset: final outputs %h", obs);
  endtask

  task automatic test_pause();
    int n;
    for (int i = 0; i < 12; i++) begin
      step(bit'(i == 0 || i == 2), 1'b0);
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL pause_arm cyc=%0d got=%h want=%h", i, obs, model_out()); end
    end
    n = 0;
    while (!(m_mode == M_RUN && model_rem() == 4) && n < 60) begin
      step(1'b0, 1'b0);
      n++;
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL pause_wait cyc=%0d got=%h want=%h", n, obs, model_out()); end
    end
    checks++;
    if (n >= 60) begin errors++; $display("FAIL pause_reach_rem4 got=timeout want=rem4"); end
    for (int i = 0; i <= 20; i++) begin
      step(bit'(i == 0), 1'b0);
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, model_out()); end
    end
`ifdef WASH_PAUSE_EN
    checks++;
    if (obs !== {4'd4, 3'b100}) begin errors++; $display("FAIL pause_frozen got=%h want=%h", obs, {4'd4, 3'b100}); end
`endif
    for (int i = 0; i < 40; i++) begin
      step(bit'(i == 0), bit'(i == 39));
      checks++;
      if (obs !== model_out()) begin errors++; $display("FAIL pause_resume cyc=%0d got=%h want=%h", i, obs, model_out()); end
`ifdef WASH_PAUSE_EN
      if (i == 3 || i == 4) begin
        checks++;
        if (obs[6:3] !== ((i == 3) ? 4'd4 : 4'd3)) begin
          errors++; $display("FAIL pause_resume_rem cyc=%0d got=%0d want=%0d", i, obs[6:3], (i == 3) ? 4 : 3);
        end
      end
`endif
    end
    $display("scenario pause (enabled=%0d): final outputs %h", PAUSE_EN, obs);
  endtask

  task automatic test_tick_div1();
    int exp_disp[6] = '{1, 1, 3, 2, 1, 0};
    bit exp_run[6]  = '{0, 0, 1, 1, 1, 0};
    bit exp_done[6] = '{0, 0, 0, 0, 0, 1};
    logic [6:0] want;
    for (int i = 0; i < 7; i++) begin
      key1 = bit'(i == 0 || i == 6);
      step(1'b0, 1'b0);
      key1 = 1'b0;
      want = (i < 6) ? {4'(exp_disp[i]), exp_run[i], exp_done[i], 1'b0} : 7'd0;
      checks++;
      if (obs1 !== want) begin errors++; $display("FAIL tick_div1 cyc=%0d got=%h want=%h", i, obs1, want); end
    end
    $display("scenario tick_div1: final outputs %h", obs1);
  endtask

  task automatic test_random();
    bit k, c;
    for (int i = 0; i < 500; i++) begin
      k = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 39) == 0);
      step(k, c);
      checks++;
      if (obs !== model_out()) begin
        errors++; $display("FAIL random cyc=%0d key=%0d cancel=%0d got=%h want=%h", i, k, c, obs, model_out());
      end
    end
    $display("scenario random: final outputs %h", obs);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_select_run();
    test_alarm();
    test_rearm();
    test_cancel_reset();
    test_pause();
    test_tick_div1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
